crop_window_stream: RTL

Runtime-configurable AXI-Stream crop stage: the successor to the fixed-size crop filter in the camera front-end. It sits between the sensor/deserializer stream and the Gaussian/feature pipeline. A crop box (X1, Y1, W, H) is loaded per frame through a config stream. Frames are delimited by an input start-of-frame flag, and cropped rows are marked with TLAST. The output is registered, with full backpressure, and carries NUM_CH packed channels per beat.

---
 rtl/crop_pkg.sv | 45 ++++
 rtl/axis_out_reg.sv | 43 ++++
 rtl/crop_window_stream.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// crop_pkg
//   Shared types and constants for the crop_window_stream block.
//   - crop_state_e : control FSM states
//   - cfg field offsets/widths for the packed {H, Y1, W, X1} config word
//   - crop_box_t   : latched crop box; fields are wide enough for any
//                    supported coordinate width so that bounds math can be
//                    done one bit wider without wrap.
package crop_pkg;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    WAIT_SOF = 2'd1,
    STREAM   = 2'd2
  } crop_state_e;

  // Box fields are stored zero-extended to this width.
  localparam int BOX_FIELD_W = 16;

  // Config word layout, X1 in the LSBs: {H, Y1, W, X1}.
  localparam int CFG_OFF_X1 = 0;

  function automatic int cfg_off_w(input int col_w);
    return col_w;
  endfunction

  function automatic int cfg_off_y1(input int col_w);
    return 2 * col_w;
  endfunction

  function automatic int cfg_off_h(input int row_w, input int col_w);
    return 2 * col_w + row_w;
  endfunction

  function automatic int cfg_width(input int row_w, input int col_w);
    return 2 * row_w + 2 * col_w;
  endfunction

  typedef struct packed {
    logic [BOX_FIELD_W-1:0] x1;
    logic [BOX_FIELD_W-1:0] y1;
    logic [BOX_FIELD_W-1:0] w;
    logic [BOX_FIELD_W-1:0] h;
  } crop_box_t;

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg
//   One-entry registered AXI-Stream slice. The payload is an opaque vector
//   (the top packs data+user+last into it). A new beat may be loaded while
//   the held beat is being consumed, giving full throughput.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/in_valid      beat to load
//   in_ready              slice can accept (empty, or draining this cycle)
//   out_data/out_valid    registered output beat
//   out_ready             downstream accept
module axis_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  assign in_ready  = ~valid_reg | out_ready;
  assign out_data  = data_reg;
  assign out_valid = valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (in_valid && in_ready) begin
      data_reg  <= in_data;
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/crop_window_stream.sv
// crop_window_stream
//   Runtime-configurable AXI-Stream crop stage. A crop box {H, Y1, W, X1}
//   is loaded per frame from the config stream; the frame starts on the
//   input TUSER beat; pixels inside the box are forwarded through a
//   registered output slice, with TUSER on the first cropped pixel and
//   TLAST on the last cropped pixel of each row.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   pixel_in_TDATA/TVALID/TREADY/TUSER  input pixel stream (TUSER = SOF)
//   cfg_TDATA/TVALID/TREADY             crop box config stream
//   pixel_out_TDATA/TVALID/TREADY       cropped output stream
//   pixel_out_TUSER/TLAST               first cropped pixel / row end
//   frame_done                          pulse after the last input pixel
//   err_cfg                             sticky, rejected config
//   err_sof                             sticky, SOF seen mid-frame
module crop_window_stream
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int NUM_CH           = 1,
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CH*PIXEL_BIT_WIDTH-1:0]     pixel_in_TDATA,
  input  logic                                  pixel_in_TVALID,
  output logic                                  pixel_in_TREADY,
  input  logic                                  pixel_in_TUSER,
  input  logic [2*IMG_ROW_BITWIDTH+2*IMG_COL_BITWIDTH-1:0] cfg_TDATA,
  input  logic                                  cfg_TVALID,
  output logic                                  cfg_TREADY,
  output logic [NUM_CH*PIXEL_BIT_WIDTH-1:0]     pixel_out_TDATA,
  output logic                                  pixel_out_TVALID,
  input  logic                                  pixel_out_TREADY,
  output logic                                  pixel_out_TUSER,
  output logic                                  pixel_out_TLAST,
  output logic                                  frame_done,
  output logic                                  err_cfg,
  output logic                                  err_sof
);

  localparam int DATA_W = NUM_CH * PIXEL_BIT_WIDTH;
  localparam int OFF_W  = cfg_off_w(IMG_COL_BITWIDTH);
  localparam int OFF_Y1 = cfg_off_y1(IMG_COL_BITWIDTH);
  localparam int OFF_H  = cfg_off_h(IMG_ROW_BITWIDTH, IMG_COL_BITWIDTH);
  // Bounds math is done one bit wider than the box fields: no wrap.
  localparam int BW     = BOX_FIELD_W + 1;

  crop_state_e                 state_reg;
  crop_box_t                   box_reg;
  logic [IMG_COL_BITWIDTH-1:0] x_reg;
  logic [IMG_ROW_BITWIDTH-1:0] y_reg;
  logic                        frame_done_reg;
  logic                        err_cfg_reg;
  logic                        err_sof_reg;

  // ---------------- config decode and validation ----------------
  crop_box_t cfg_box;
  logic [BW-1:0] cfg_x_end, cfg_y_end;
  logic cfg_ok, cfg_fire;

  always_comb begin
    cfg_box.x1 = BOX_FIELD_W'(cfg_TDATA[CFG_OFF_X1 +: IMG_COL_BITWIDTH]);
    cfg_box.w  = BOX_FIELD_W'(cfg_TDATA[OFF_W      +: IMG_COL_BITWIDTH]);
    cfg_box.y1 = BOX_FIELD_W'(cfg_TDATA[OFF_Y1     +: IMG_ROW_BITWIDTH]);
    cfg_box.h  = BOX_FIELD_W'(cfg_TDATA[OFF_H      +: IMG_ROW_BITWIDTH]);
    cfg_x_end  = BW'(cfg_box.x1) + BW'(cfg_box.w);
    cfg_y_end  = BW'(cfg_box.y1) + BW'(cfg_box.h);
    cfg_ok     = (cfg_box.w != '0) && (cfg_box.h != '0) &&
                 (cfg_x_end <= BW'(IN_COLS)) && (cfg_y_end <= BW'(IN_ROWS));
  end

  assign cfg_TREADY = !reset && (state_reg == WAIT_CFG);
  assign cfg_fire   = cfg_TVALID && cfg_TREADY;

  // ---------------- pixel acceptance and crop test ----------------
  logic slice_in_ready;
  logic in_fire, frame_beat, sof_mid, load;
  logic [IMG_COL_BITWIDTH-1:0] cur_x;
  logic [IMG_ROW_BITWIDTH-1:0] cur_y;
  logic [BW-1:0] cx, cy, x_lo, x_hi, y_lo, y_hi;
  logic in_box, out_user, out_last, end_col, end_frame;

  // The output slice ready also gates WAIT_SOF: a stalled last pixel of
  // the previous frame can still be held there, and the SOF beat may need
  // to load the slice.
  assign pixel_in_TREADY = !reset && (state_reg != WAIT_CFG) && slice_in_ready;
  assign in_fire         = pixel_in_TVALID && pixel_in_TREADY;

  always_comb begin
    // Any SOF beat is pixel (0,0), whether it starts or restarts a frame.
    cur_x      = pixel_in_TUSER ? '0 : x_reg;
    cur_y      = pixel_in_TUSER ? '0 : y_reg;
    // In WAIT_SOF only the SOF beat belongs to the frame; the rest drop.
    frame_beat = in_fire && (pixel_in_TUSER || (state_reg == STREAM));
    sof_mid    = in_fire && (state_reg == STREAM) && pixel_in_TUSER &&
                 ((x_reg != '0) || (y_reg != '0));
    cx         = BW'(cur_x);
    cy         = BW'(cur_y);
    x_lo       = BW'(box_reg.x1);
    y_lo       = BW'(box_reg.y1);
    x_hi       = x_lo + BW'(box_reg.w);
    y_hi       = y_lo + BW'(box_reg.h);
    in_box     = (cx >= x_lo) && (cx < x_hi) && (cy >= y_lo) && (cy < y_hi);
    out_user   = (cx == x_lo) && (cy == y_lo);
    out_last   = (cx == x_hi - BW'(1));
    load       = frame_beat && in_box;
    end_col    = (cur_x == IMG_COL_BITWIDTH'(IN_COLS - 1));
    end_frame  = end_col && (cur_y == IMG_ROW_BITWIDTH'(IN_ROWS - 1));
  end

  // ---------------- control FSM and coordinate counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= WAIT_CFG;
      box_reg        <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      frame_done_reg <= 1'b0;
      err_cfg_reg    <= 1'b0;
      err_sof_reg    <= 1'b0;
    end else begin
      frame_done_reg <= frame_beat && end_frame;
      case (state_reg)
        WAIT_CFG: begin
          if (cfg_fire) begin
            if (cfg_ok) begin
              box_reg     <= cfg_box;
              err_cfg_reg <= 1'b0;
              err_sof_reg <= 1'b0;
              x_reg       <= '0;
              y_reg       <= '0;
              state_reg   <= WAIT_SOF;
            end else begin
              err_cfg_reg <= 1'b1;
            end
          end
        end
        WAIT_SOF, STREAM: begin
          if (frame_beat) begin
            if (sof_mid) err_sof_reg <= 1'b1;
            if (end_col) begin
              x_reg <= '0;
              y_reg <= end_frame ? '0 : cur_y + 1'b1;
            end else begin
              x_reg <= cur_x + 1'b1;
              y_reg <= cur_y;
            end
            state_reg <= end_frame ? WAIT_CFG : STREAM;
          end
        end
        default: state_reg <= WAIT_CFG;
      endcase
    end
  end

  assign frame_done = frame_done_reg;
  assign err_cfg    = err_cfg_reg;
  assign err_sof    = err_sof_reg;

  // ---------------- registered output slice ----------------
  logic [DATA_W+1:0] slice_out;

  axis_out_reg #(
    .WIDTH(DATA_W + 2)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .in_data  ({pixel_in_TDATA, out_user, out_last}),
    .in_valid (load),
    .in_ready (slice_in_ready),
    .out_data (slice_out),
    .out_valid(pixel_out_TVALID),
    .out_ready(pixel_out_TREADY)
  );

  assign {pixel_out_TDATA, pixel_out_TUSER, pixel_out_TLAST} = slice_out;

endmodule
